// File: rtl/sdprf_fifo_s.sv
// Purpose : show-ahead synchronous FIFO built on an inferred simple-dual-port register file.
// Latency : write into an empty queue becomes visible on o_rdata two edges later; 1 word/cycle once primed.
// Backpres: i_wr is dropped while o_full=1 (sets o_ovf); i_rd is ignored while o_empty=1 (sets o_udf).
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_wr, i_wdata        write strobe and data
//   o_full, o_afull      registered fill flags derived from o_usedw
//   i_rd, o_rdata        pop strobe and head-of-queue word (valid while o_empty=0)
//   o_empty, o_usedw     head not presented / words accepted and not yet popped
//   o_ovf, o_udf         sticky overflow / underflow flags, cleared by i_clr_err
module sdprf_fifo_s #(
   parameter int DATA_W   = 22,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int AFULL_TH = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_full,
   output logic              o_afull,
   input  logic              i_rd,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_empty,
   output logic [ADDR_W:0]   o_usedw,
   output logic              o_ovf,
   output logic              o_udf,
   input  logic              i_clr_err
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   // Words sitting in the RAM that have not yet been loaded into the head register.
   logic [ADDR_W:0]   r_avail;
   logic [ADDR_W:0]   r_usedw;
   logic              r_full;
   logic              r_afull;
   logic [DATA_W-1:0] r_rdata;
   logic              r_ovf;
   logic              r_udf;
   logic [1:0]        r_state;

   logic              w_wr_ok;
   logic              w_rd_ok;
   logic              w_avail_nz;
   logic              w_load;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W:0]   w_usedw_nxt;
   logic [ADDR_W:0]   w_avail_nxt;

   // Qualification uses this cycle's registered flags only.
   assign w_wr_ok    = i_wr & ~r_full;
   assign w_rd_ok    = i_rd & (r_state == ST_VALID);
   assign w_avail_nz = (r_avail != '0);

   // Prefetch control. w_load moves mem[r_rptr] into the head register at the
   // coming edge; the read port is thus registered straight into o_rdata.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_avail_nz) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            w_load      = 1'b1;
            w_state_nxt = ST_VALID;
         end
         ST_VALID: begin
            if (w_rd_ok) begin
               if (w_avail_nz) begin
                  w_load = 1'b1;  // back-to-back reload, head stays valid
               end else if (w_wr_ok) begin
                  w_state_nxt = ST_FETCH;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   assign w_usedw_nxt = r_usedw + (ADDR_W+1)'(w_wr_ok) - (ADDR_W+1)'(w_rd_ok);
   assign w_avail_nxt = r_avail + (ADDR_W+1)'(w_wr_ok) - (ADDR_W+1)'(w_load);

   // Storage array is not reset; only the control state is.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_EMPTY;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_avail <= '0;
         r_usedw <= '0;
         r_full  <= 1'b0;
         r_afull <= 1'b0;
         r_rdata <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_avail <= w_avail_nxt;
         r_usedw <= w_usedw_nxt;
         r_full  <= (w_usedw_nxt == (ADDR_W+1)'(DEPTH));
         r_afull <= (w_usedw_nxt >= (ADDR_W+1)'(AFULL_TH));
         if (w_wr_ok) r_wptr <= r_wptr + ADDR_W'(1);
         if (w_load) begin
            r_rdata <= r_mem[r_rptr];
            r_rptr  <= r_rptr + ADDR_W'(1);
         end
         // A new error in the same cycle as a clear keeps the flag set.
         r_ovf <= (r_ovf & ~i_clr_err) | (i_wr & r_full);
         r_udf <= (r_udf & ~i_clr_err) | (i_rd & (r_state != ST_VALID));
      end
   end

   assign o_full  = r_full;
   assign o_afull = r_afull;
   assign o_rdata = r_rdata;
   assign o_empty = (r_state != ST_VALID);
   assign o_usedw = r_usedw;
   assign o_ovf   = r_ovf;
   assign o_udf   = r_udf;

endmodule

// File: tb/tb_sdprf_fifo_s.sv
module tb_sdprf_fifo_s;

   localparam int DW    = 22;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TH    = 12;

   logic          i_clk     = 1'b0;
   logic          i_rst_n   = 1'b0;
   logic          i_wr      = 1'b0;
   logic [DW-1:0] i_wdata   = '0;
   logic          i_rd      = 1'b0;
   logic          i_clr_err = 1'b0;
   logic          o_full, o_afull, o_empty, o_ovf, o_udf;
   logic [DW-1:0] o_rdata;
   logic [AW:0]   o_usedw;

   int checks = 0;
   int errors = 0;

   // Reference model: plain queue of accepted, not yet popped words plus sticky flags.
   logic [DW-1:0] mq[$];
   bit            m_ovf, m_udf;

   sdprf_fifo_s #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .AFULL_TH(TH)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr      (i_wr),
      .i_wdata   (i_wdata),
      .o_full    (o_full),
      .o_afull   (o_afull),
      .i_rd      (i_rd),
      .o_rdata   (o_rdata),
      .o_empty   (o_empty),
      .o_usedw   (o_usedw),
      .o_ovf     (o_ovf),
      .o_udf     (o_udf),
      .i_clr_err (i_clr_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Bounded wait for the head word to be presented.
   task automatic wait_valid(output bit ok);
      for (int i = 0; i < 8 && o_empty; i++) tick();
      ok = !o_empty;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", o_empty); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
      checks++; if (o_afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", o_afull); end
      checks++; if (o_usedw !== 5'd0) begin errors++; $display("FAIL reset_usedw: got %0d want 0", o_usedw); end
      checks++; if (o_rdata !== 22'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", o_rdata); end
      checks++; if (o_ovf !== 1'b0 || o_udf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b udf=%b want 0 0", o_ovf, o_udf); end
   endtask

   task automatic test_latency();
      i_wr = 1'b1; i_wdata = 22'h3A5A5;
      tick();                                   // edge 0
      i_wr = 1'b0;
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL lat_edge0_empty: got %b want 1", o_empty); end
      checks++; if (o_usedw !== 5'd1) begin errors++; $display("FAIL lat_usedw: got %0d want 1", o_usedw); end
      tick();                                   // edge 1
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL lat_edge1_empty: got %b want 1", o_empty); end
      tick();                                   // edge 2
      checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL lat_edge2_empty: got %b want 0", o_empty); end
      checks++; if (o_rdata !== 22'h3A5A5) begin errors++; $display("FAIL lat_rdata: got %h want 3a5a5", o_rdata); end
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
      checks++; if (o_empty !== 1'b1 || o_usedw !== 5'd0) begin errors++; $display("FAIL lat_pop: got empty=%b usedw=%0d want 1 0", o_empty, o_usedw); end
   endtask

   task automatic test_fill();
      bit ok;
      for (int k = 0; k < DEPTH; k++) begin
         i_wr = 1'b1; i_wdata = DW'(k);
         tick();
         checks++; if (o_usedw !== 5'(k+1)) begin errors++; $display("FAIL fill_usedw[%0d]: got %0d want %0d", k, o_usedw, k+1); end
         checks++; if (o_afull !== ((k+1) >= TH)) begin errors++; $display("FAIL fill_afull[%0d]: got %b want %b", k, o_afull, (k+1) >= TH); end
         checks++; if (o_full !== ((k+1) == DEPTH)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", k, o_full, (k+1) == DEPTH); end
      end
      i_wdata = 22'h3FFFF;                      // 17th write, must be dropped
      tick();
      i_wr = 1'b0;
      checks++; if (o_usedw !== 5'd16) begin errors++; $display("FAIL ovf_usedw: got %0d want 16", o_usedw); end
      checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o_ovf); end
      for (int k = 0; k < DEPTH; k++) begin
         wait_valid(ok);
         checks++; if (!ok) begin errors++; $display("FAIL drain_timeout[%0d]: got empty want data", k); end
         checks++; if (o_rdata !== DW'(k)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", k, o_rdata, DW'(k)); end
         i_rd = 1'b1;
         tick();
         i_rd = 1'b0;
      end
      checks++; if (o_empty !== 1'b1 || o_usedw !== 5'd0) begin errors++; $display("FAIL drain_end: got empty=%b usedw=%0d want 1 0", o_empty, o_usedw); end
      i_clr_err = 1'b1;
      tick();
      i_clr_err = 1'b0;
      checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", o_ovf); end
   endtask

   task automatic test_full_wr_rd();
      bit ok;
      for (int k = 0; k < DEPTH; k++) begin
         i_wr = 1'b1; i_wdata = DW'(100 + k);
         tick();
      end
      i_wr = 1'b0;
      wait_valid(ok);
      i_wr = 1'b1; i_wdata = 22'h2BEEF; i_rd = 1'b1;
      tick();
      i_wr = 1'b0; i_rd = 1'b0;
      checks++; if (o_usedw !== 5'd15) begin errors++; $display("FAIL fullwr_usedw: got %0d want 15", o_usedw); end
      checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL fullwr_ovf: got %b want 1", o_ovf); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL fullwr_full: got %b want 0", o_full); end
      for (int k = 1; k < DEPTH; k++) begin
         wait_valid(ok);
         checks++; if (!ok || o_rdata !== DW'(100 + k)) begin errors++; $display("FAIL fullwr_drain[%0d]: got %h want %h", k, o_rdata, DW'(100 + k)); end
         i_rd = 1'b1;
         tick();
         i_rd = 1'b0;
      end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL fullwr_end: got empty=%b want 1", o_empty); end
      i_clr_err = 1'b1;
      tick();
      i_clr_err = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      int base = 22'h10000;
      for (int k = 0; k < 8; k++) begin
         i_wr = 1'b1; i_wdata = DW'(base + k);
         tick();
      end
      i_wr = 1'b0;
      wait_valid(ok);
      tick();
      for (int c = 0; c < 64; c++) begin
         checks++; if (o_empty !== 1'b0 || o_rdata !== DW'(base + c)) begin errors++; $display("FAIL stream_head[%0d]: got empty=%b data=%h want 0 %h", c, o_empty, o_rdata, DW'(base + c)); end
         i_wr = 1'b1; i_wdata = DW'(base + 8 + c); i_rd = 1'b1;
         tick();
         checks++; if (o_usedw !== 5'd8) begin errors++; $display("FAIL stream_usedw[%0d]: got %0d want 8", c, o_usedw); end
      end
      i_wr = 1'b0; i_rd = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wait_valid(ok);
         checks++; if (!ok || o_rdata !== DW'(base + 64 + k)) begin errors++; $display("FAIL stream_drain[%0d]: got %h want %h", k, o_rdata, DW'(base + 64 + k)); end
         i_rd = 1'b1;
         tick();
         i_rd = 1'b0;
      end
      i_rd = 1'b1;                              // pop on empty
      tick();
      i_rd = 1'b0;
      checks++; if (o_udf !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b want 1", o_udf); end
      checks++; if (o_usedw !== 5'd0) begin errors++; $display("FAIL udf_usedw: got %0d want 0", o_usedw); end
      i_clr_err = 1'b1;
      tick();
      i_clr_err = 1'b0;
      checks++; if (o_udf !== 1'b0) begin errors++; $display("FAIL clr_udf: got %b want 0", o_udf); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      for (int k = 0; k < 5; k++) begin
         i_wr = 1'b1; i_wdata = DW'(22'h0AAAA + k);
         tick();
      end
      i_wr = 1'b0;
      wait_valid(ok);
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      checks++; if (o_empty !== 1'b1 || o_usedw !== 5'd0) begin errors++; $display("FAIL midrst_state: got empty=%b usedw=%0d want 1 0", o_empty, o_usedw); end
      checks++; if (o_rdata !== 22'h0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", o_rdata); end
      i_wr = 1'b1; i_wdata = 22'h01234;
      tick();
      i_wr = 1'b0;
      wait_valid(ok);
      checks++; if (!ok || o_rdata !== 22'h01234) begin errors++; $display("FAIL midrst_new: got %h want 01234", o_rdata); end
      checks++; if (o_usedw !== 5'd1) begin errors++; $display("FAIL midrst_usedw: got %0d want 1", o_usedw); end
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
      tick();
      checks++; if (o_empty !== 1'b1 || o_usedw !== 5'd0) begin errors++; $display("FAIL midrst_end: got empty=%b usedw=%0d want 1 0", o_empty, o_usedw); end
   endtask

   task automatic test_random();
      int  stall = 0;
      int  wp, rp, sz;
      bit  wr, rd, clr, full_now;
      logic [DW-1:0] d;
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         sz = mq.size();
         checks++; if (o_usedw !== 5'(sz)) begin errors++; $display("FAIL rnd_usedw@%0d: got %0d want %0d", cyc, o_usedw, sz); end
         checks++; if (o_full !== (sz == DEPTH) || o_afull !== (sz >= TH)) begin errors++; $display("FAIL rnd_fill@%0d: got full=%b afull=%b want %b %b", cyc, o_full, o_afull, sz == DEPTH, sz >= TH); end
         checks++; if (o_ovf !== m_ovf || o_udf !== m_udf) begin errors++; $display("FAIL rnd_flags@%0d: got ovf=%b udf=%b want %b %b", cyc, o_ovf, o_udf, m_ovf, m_udf); end
         if (sz == 0) begin
            checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rnd_empty@%0d: got %b want 1", cyc, o_empty); end
         end else if (!o_empty) begin
            checks++; if (o_rdata !== mq[0]) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, o_rdata, mq[0]); end
         end
         stall = (sz > 0 && o_empty) ? stall + 1 : 0;
         checks++; if (stall > 2) begin errors++; $display("FAIL rnd_stall@%0d: got %0d empty cycles want <=2", cyc, stall); end

         case ((cyc / 200) % 3)
            0:       begin wp = 25; rp = 70; end
            1:       begin wp = 50; rp = 50; end
            default: begin wp = 90; rp = 20; end
         endcase
         wr  = ($urandom_range(0, 99) < wp);
         rd  = ($urandom_range(0, 99) < rp);
         clr = ($urandom_range(0, 15) == 0);
         d   = DW'($urandom);
         i_wr = wr; i_wdata = d; i_rd = rd; i_clr_err = clr;

         full_now = (sz == DEPTH);
         m_ovf = (m_ovf && !clr) || (wr && full_now);
         m_udf = (m_udf && !clr) || (rd && o_empty);
         if (rd && !o_empty && sz > 0) void'(mq.pop_front());
         if (wr && !full_now) mq.push_back(d);
         tick();
      end
      i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fill();
      test_full_wr_rd();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
